// File: rtl/multi_ball_engine.sv
// rtl/multi_ball_engine.sv - game FSM, fractional-speed multi-ball stepping and paddle control
module multi_ball_engine #(
    parameter int N_BALLS = 2,
    parameter int COORD_W = 10,
    parameter int SPD_W   = 16,
    parameter int ACC_W   = 22,
    parameter int UNIT    = 2000000,
    parameter int LEFT    = 160,
    parameter int TOP     = 0,
    parameter int MAXX    = 320,
    parameter int MAXY    = 480,
    parameter int RADIUS  = 8,
    parameter int PD_SZ   = 10,
    parameter int PD_LEN  = 20,
    parameter int PD_STEP = 4,
    parameter int PD_DIV  = 500000,
    parameter int VX0     = 5,
    parameter int VY0     = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       btn_l,
    input  logic                       btn_r,
    input  logic                       ld_valid,
    input  logic [2:0]                 ld_idx,
    input  logic [SPD_W-1:0]           ld_vx,
    input  logic [SPD_W-1:0]           ld_vy,
    output logic [N_BALLS*COORD_W-1:0] o_bx,
    output logic [N_BALLS*COORD_W-1:0] o_by,
    output logic [N_BALLS-1:0]         b_active,
    output logic [COORD_W-1:0]         o_pdx,
    output logic [1:0]                 o_state,
    output logic                       lose
);

    localparam logic [COORD_W-1:0] CX      = COORD_W'(LEFT + MAXX / 2);
    localparam logic [COORD_W-1:0] CY      = COORD_W'(TOP + MAXY / 2);
    localparam logic [COORD_W-1:0] XL      = COORD_W'(LEFT + RADIUS);
    localparam logic [COORD_W-1:0] XR      = COORD_W'(LEFT + MAXX - RADIUS);
    localparam logic [COORD_W-1:0] YT      = COORD_W'(TOP + RADIUS);
    localparam logic [COORD_W-1:0] YB      = COORD_W'(TOP + MAXY - PD_SZ - RADIUS);
    localparam logic [COORD_W:0]   PD_MIN  = (COORD_W+1)'(LEFT + PD_LEN);
    localparam logic [COORD_W:0]   PD_MAX  = (COORD_W+1)'(LEFT + MAXX - PD_LEN);
    localparam logic [COORD_W:0]   PD_STP  = (COORD_W+1)'(PD_STEP);
    localparam logic [COORD_W:0]   HIT_D   = (COORD_W+1)'(PD_LEN + RADIUS);
    localparam logic [ACC_W:0]     L_UNIT  = (ACC_W+1)'(UNIT);
    localparam int                 DIV_W   = (PD_DIV > 1) ? $clog2(PD_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_END = DIV_W'(PD_DIV - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_WAIT = 2'b01,
        S_PLAY = 2'b10,
        S_DEAD = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_start_q;
    logic                 w_st_edge;
    logic                 w_restart;

    logic [COORD_W-1:0]   r_bx   [N_BALLS];
    logic [COORD_W-1:0]   r_by   [N_BALLS];
    logic [ACC_W-1:0]     r_accx [N_BALLS];
    logic [ACC_W-1:0]     r_accy [N_BALLS];
    logic [SPD_W-1:0]     r_vx   [N_BALLS];
    logic [SPD_W-1:0]     r_vy   [N_BALLS];
    logic [N_BALLS-1:0]   r_dxr;
    logic [N_BALLS-1:0]   r_dyd;
    logic [N_BALLS-1:0]   r_act;
    logic                 r_lose;

    logic [COORD_W-1:0]   r_pdx;
    logic [DIV_W-1:0]     r_div;
    logic                 w_tick;
    logic [COORD_W:0]     w_pd_up;
    logic [COORD_W:0]     w_pd_dn;

    logic [ACC_W:0]         w_sum_x [N_BALLS];
    logic [ACC_W:0]         w_sum_y [N_BALLS];
    logic [ACC_W-1:0]       w_naccx [N_BALLS];
    logic [ACC_W-1:0]       w_naccy [N_BALLS];
    logic signed [COORD_W:0] w_dx   [N_BALLS];
    logic [COORD_W:0]       w_adx   [N_BALLS];
    logic [N_BALLS-1:0]     w_stx;
    logic [N_BALLS-1:0]     w_sty;
    logic [N_BALLS-1:0]     w_hit;
    logic [N_BALLS-1:0]     w_lost;

    assign w_st_edge = start & ~r_start_q;
    assign w_restart = (r_state == S_DEAD) && w_st_edge;

    // Game state register and start-button history for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_INIT;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_q <= start;
        end
    end

    // Next game state: start edges step through the rounds, losing every ball ends one
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  if (w_st_edge)      w_next = S_WAIT;
            S_WAIT:  if (w_st_edge)      w_next = S_PLAY;
            S_PLAY:  if (r_act == '0)    w_next = S_DEAD;
            S_DEAD:  if (w_st_edge)      w_next = S_INIT;
            default:                     w_next = S_INIT;
        endcase
    end

    // Per-ball accumulator sums, step events and paddle hit/loss decisions
    always_comb begin
        for (int i = 0; i < N_BALLS; i++) begin
            w_sum_x[i] = {1'b0, r_accx[i]} + {{(ACC_W+1-SPD_W){1'b0}}, r_vx[i]};
            w_sum_y[i] = {1'b0, r_accy[i]} + {{(ACC_W+1-SPD_W){1'b0}}, r_vy[i]};
            w_stx[i]   = (w_sum_x[i] >= L_UNIT);
            w_sty[i]   = (w_sum_y[i] >= L_UNIT);
            w_naccx[i] = w_stx[i] ? ACC_W'(w_sum_x[i] - L_UNIT) : w_sum_x[i][ACC_W-1:0];
            w_naccy[i] = w_sty[i] ? ACC_W'(w_sum_y[i] - L_UNIT) : w_sum_y[i][ACC_W-1:0];
            w_dx[i]    = $signed({1'b0, r_bx[i]}) - $signed({1'b0, r_pdx});
            w_adx[i]   = w_dx[i][COORD_W] ? $unsigned(-w_dx[i]) : $unsigned(w_dx[i]);
            w_hit[i]   = (w_adx[i] <= HIT_D);
            w_lost[i]  = (r_state == S_PLAY) && r_act[i] && w_sty[i] && r_dyd[i]
                         && (r_by[i] >= YB) && !w_hit[i];
        end
    end

    // Ball positions, directions, accumulators, activity and the loss pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_act  <= '0;
            r_lose <= 1'b0;
            for (int i = 0; i < N_BALLS; i++) begin
                r_bx[i]   <= CX;
                r_by[i]   <= CY;
                r_accx[i] <= '0;
                r_accy[i] <= '0;
                r_dxr[i]  <= (i % 2 == 0);
                r_dyd[i]  <= 1'b0;
            end
        end else begin
            r_lose <= 1'b0;
            case (r_state)
                S_INIT, S_WAIT: begin
                    if ((r_state == S_INIT) && w_st_edge) begin
                        r_act <= '1;
                    end
                    for (int i = 0; i < N_BALLS; i++) begin
                        r_bx[i]   <= CX;
                        r_by[i]   <= CY;
                        r_accx[i] <= '0;
                        r_accy[i] <= '0;
                    end
                end
                S_PLAY: begin
                    r_lose <= |w_lost;
                    for (int i = 0; i < N_BALLS; i++) begin
                        if (r_act[i]) begin
                            r_accx[i] <= w_naccx[i];
                            r_accy[i] <= w_naccy[i];
                            if (w_lost[i]) begin
                                // a lost ball freezes exactly where it left the field
                                r_act[i] <= 1'b0;
                            end else begin
                                if (w_stx[i]) begin
                                    if (r_dxr[i]) begin
                                        if (r_bx[i] >= XR) r_dxr[i] <= 1'b0;
                                        else               r_bx[i]  <= r_bx[i] + 1'b1;
                                    end else begin
                                        if (r_bx[i] <= XL) r_dxr[i] <= 1'b1;
                                        else               r_bx[i]  <= r_bx[i] - 1'b1;
                                    end
                                end
                                if (w_sty[i]) begin
                                    if (r_dyd[i]) begin
                                        // at YB here means the paddle was hit
                                        if (r_by[i] >= YB) r_dyd[i] <= 1'b0;
                                        else               r_by[i]  <= r_by[i] + 1'b1;
                                    end else begin
                                        if (r_by[i] <= YT) r_dyd[i] <= 1'b1;
                                        else               r_by[i]  <= r_by[i] - 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                default: begin
                    if (w_restart) begin
                        r_act <= '0;
                        for (int i = 0; i < N_BALLS; i++) begin
                            r_bx[i]   <= CX;
                            r_by[i]   <= CY;
                            r_accx[i] <= '0;
                            r_accy[i] <= '0;
                            r_dxr[i]  <= (i % 2 == 0);
                            r_dyd[i]  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Speed words: loadable before play starts, kept across rounds
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BALLS; i++) begin
                r_vx[i] <= SPD_W'(VX0);
                r_vy[i] <= SPD_W'(VY0);
            end
        end else if (ld_valid && ((r_state == S_INIT) || (r_state == S_WAIT))) begin
            for (int i = 0; i < N_BALLS; i++) begin
                if (ld_idx == 3'(i)) begin
                    r_vx[i] <= ld_vx;
                    r_vy[i] <= ld_vy;
                end
            end
        end
    end

    // Free-running paddle tick divider
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (r_div == DIV_END) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick  = (r_div == DIV_END);
    assign w_pd_up = {1'b0, r_pdx} + PD_STP;
    assign w_pd_dn = {1'b0, r_pdx} - PD_STP;

    // Paddle position: one clamped step per tick while exactly one button is held
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pdx <= CX;
        end else if (w_restart) begin
            r_pdx <= CX;
        end else if (((r_state == S_WAIT) || (r_state == S_PLAY)) && w_tick && (btn_l ^ btn_r)) begin
            if (btn_r) begin
                r_pdx <= (w_pd_up > PD_MAX) ? PD_MAX[COORD_W-1:0] : w_pd_up[COORD_W-1:0];
            end else begin
                r_pdx <= ({1'b0, r_pdx} < (PD_MIN + PD_STP)) ? PD_MIN[COORD_W-1:0]
                                                             : w_pd_dn[COORD_W-1:0];
            end
        end
    end

    // Pack per-ball registers onto the renderer-facing buses
    always_comb begin
        o_bx = '0;
        o_by = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            o_bx[i*COORD_W +: COORD_W] = r_bx[i];
            o_by[i*COORD_W +: COORD_W] = r_by[i];
        end
    end

    assign b_active = r_act;
    assign o_pdx    = r_pdx;
    assign o_state  = r_state;
    assign lose     = r_lose;

endmodule

// File: tb/tb_multi_ball_engine.sv
// tb/tb_multi_ball_engine.sv - directed self-checking bench for multi_ball_engine
module tb_multi_ball_engine;

    localparam int NB = 2;
    localparam int CW = 10;
    localparam int SW = 22;
    localparam int U  = 2000000;

    logic              clock;
    logic              reset;
    logic              start;
    logic              btn_l;
    logic              btn_r;
    logic              ld_valid;
    logic [2:0]        ld_idx;
    logic [SW-1:0]     ld_vx;
    logic [SW-1:0]     ld_vy;
    logic [NB*CW-1:0]  o_bx;
    logic [NB*CW-1:0]  o_by;
    logic [NB-1:0]     b_active;
    logic [CW-1:0]     o_pdx;
    logic [1:0]        o_state;
    logic              lose;

    int n_pass  = 0;
    int n_total = 0;

    multi_ball_engine #(
        .N_BALLS (NB),
        .COORD_W (CW),
        .SPD_W   (SW),
        .PD_DIV  (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .btn_l    (btn_l),
        .btn_r    (btn_r),
        .ld_valid (ld_valid),
        .ld_idx   (ld_idx),
        .ld_vx    (ld_vx),
        .ld_vy    (ld_vy),
        .o_bx     (o_bx),
        .o_by     (o_by),
        .b_active (b_active),
        .o_pdx    (o_pdx),
        .o_state  (o_state),
        .lose     (lose)
    );

    typedef struct {
        logic s;
        logic r;
        int   st;
        int   act;
        int   pdx;
        int   bx0;
    } vec_t;

    vec_t vecs [10];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic int bx_of(input int i);
        return int'(o_bx[i*CW +: CW]);
    endfunction

    function automatic int by_of(input int i);
        return int'(o_by[i*CW +: CW]);
    endfunction

    task automatic load(input int idx, input int vx, input int vy);
        ld_valid = 1'b1;
        ld_idx   = 3'(idx);
        ld_vx    = SW'(vx);
        ld_vy    = SW'(vy);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bx0"}, bx_of(0), 320);
        chk({tag, "_bx1"}, bx_of(1), 320);
        chk({tag, "_by0"}, by_of(0), 240);
        chk({tag, "_by1"}, by_of(1), 240);
        chk({tag, "_act"}, int'(b_active), 0);
        chk({tag, "_pdx"}, int'(o_pdx), 320);
        chk({tag, "_state"}, int'(o_state), 0);
        chk({tag, "_lose"}, int'(lose), 0);
    endtask

    initial begin
        int found;
        int last;
        int prev;
        int n_lose;
        int seen;

        vecs[0] = '{s: 1'b0, r: 1'b1, st: 0, act: 0, pdx: 320, bx0: 320};
        vecs[1] = '{s: 1'b0, r: 1'b1, st: 0, act: 0, pdx: 320, bx0: 320};
        vecs[2] = '{s: 1'b0, r: 1'b1, st: 0, act: 0, pdx: 320, bx0: 320};
        vecs[3] = '{s: 1'b0, r: 1'b1, st: 0, act: 0, pdx: 320, bx0: 320};
        vecs[4] = '{s: 1'b0, r: 1'b1, st: 0, act: 0, pdx: 320, bx0: 320};
        vecs[5] = '{s: 1'b1, r: 1'b0, st: 1, act: 3, pdx: 320, bx0: 320};
        vecs[6] = '{s: 1'b1, r: 1'b0, st: 1, act: 3, pdx: 320, bx0: 320};
        vecs[7] = '{s: 1'b1, r: 1'b0, st: 1, act: 3, pdx: 320, bx0: 320};
        vecs[8] = '{s: 1'b0, r: 1'b0, st: 1, act: 3, pdx: 320, bx0: 320};
        vecs[9] = '{s: 1'b1, r: 1'b0, st: 2, act: 3, pdx: 320, bx0: 320};

        reset    = 1'b0;
        start    = 1'b0;
        btn_l    = 1'b0;
        btn_r    = 1'b0;
        ld_valid = 1'b0;
        ld_idx   = '0;
        ld_vx    = '0;
        ld_vy    = '0;

        // reset values
        repeat (2) @(negedge clock);
        chk_reset_vals("reset");
        reset = 1'b1;

        // speeds for the wall-bounce run
        load(0, U, 0);
        load(1, 0, 0);

        // start sequencing, held start, paddle frozen in INIT
        for (int k = 0; k < 10; k++) begin
            start = vecs[k].s;
            btn_r = vecs[k].r;
            tick();
            chk($sformatf("vec%0d_state", k), int'(o_state), vecs[k].st);
            chk($sformatf("vec%0d_act", k), int'(b_active), vecs[k].act);
            chk($sformatf("vec%0d_pdx", k), int'(o_pdx), vecs[k].pdx);
            chk($sformatf("vec%0d_bx0", k), bx_of(0), vecs[k].bx0);
        end

        // wall bounce with a load attempt during PLAY that must be ignored
        for (int k = 1; k <= 152; k++) begin
            start    = 1'b0;
            ld_valid = (k == 10);
            ld_idx   = 3'd0;
            ld_vx    = '0;
            ld_vy    = '0;
            tick();
            if (k == 100) chk("wall_bx0_mid", bx_of(0), 420);
        end
        ld_valid = 1'b0;
        chk("wall_bx0_limit", bx_of(0), 472);
        chk("wall_by0_still", by_of(0), 240);
        chk("wall_bx1_zero_speed", bx_of(1), 320);
        tick();
        chk("wall_flip_hold", bx_of(0), 472);
        tick();
        chk("wall_after_flip", bx_of(0), 471);
        tick();
        chk("wall_after_flip2", bx_of(0), 470);

        // asynchronous reset mid-PLAY
        reset = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clock);
        reset = 1'b1;

        // vertical-only speeds, both balls identical
        load(0, 0, U);
        load(1, 0, U);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("wait_state", int'(o_state), 1);
        chk("wait_by0_frozen", by_of(0), 240);

        // paddle stepping every 4 clocks by 4 px
        btn_r = 1'b1;
        last  = -1;
        prev  = int'(o_pdx);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (int'(o_pdx) != prev) begin
                chk("pd_inc", int'(o_pdx) - prev, 4);
                if (last >= 0) chk("pd_gap", k - last, 4);
                last = k;
                prev = int'(o_pdx);
            end
            if (int'(o_pdx) >= 340) break;
        end
        btn_r = 1'b0;
        chk("pd_at_340", int'(o_pdx), 340);
        btn_l = 1'b1;
        btn_r = 1'b1;
        repeat (12) tick();
        chk("pd_both_hold", int'(o_pdx), 340);
        btn_l = 1'b0;
        btn_r = 1'b0;

        // PLAY: balls rise, bounce off the ceiling and hit the paddle
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("play_state", int'(o_state), 2);
        n_lose = 0;
        found  = -1;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (lose) n_lose++;
            if (by_of(0) == 462) begin
                found = k;
                break;
            end
        end
        chk("hit_arrival_cycles", found, 687);
        tick();
        chk("hit_flip_hold", by_of(0), 462);
        chk("hit_act", int'(b_active), 3);
        tick();
        chk("hit_rising", by_of(0), 461);
        chk("hit_no_lose", n_lose, 0);

        // paddle saturates at the right clamp, then both balls miss
        btn_r = 1'b1;
        repeat (150) begin
            tick();
            if (lose) n_lose++;
        end
        chk("pd_saturate", int'(o_pdx), 460);
        seen = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (lose) begin
                n_lose++;
                seen = 1;
                break;
            end
        end
        chk("lose_seen", seen, 1);
        chk("lose_pdx", int'(o_pdx), 460);
        chk("lose_act", int'(b_active), 0);
        chk("lose_by0", by_of(0), 462);
        chk("lose_by1", by_of(1), 462);
        chk("lose_state_play", int'(o_state), 2);
        tick();
        if (lose) n_lose++;
        chk("dead_state", int'(o_state), 3);
        chk("dead_lose_low", int'(lose), 0);
        tick();
        if (lose) n_lose++;
        chk("dead_by0_frozen", by_of(0), 462);
        chk("lose_pulses", n_lose, 1);

        // DEAD -> INIT restores positions and paddle, keeps loaded speeds
        btn_r = 1'b0;
        start = 1'b1;
        tick();
        chk_reset_vals("restart");
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("restart_wait_act", int'(b_active), 3);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_play", int'(o_state), 2);
        tick();
        chk("speed_kept_by0", by_of(0), 239);
        chk("speed_kept_by1", by_of(1), 239);
        chk("speed_kept_bx0", bx_of(0), 320);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
